spi_tx_sequencer: RTL
=====================

SPI_TX_SEQUENCER -- requirements
Module: spi_tx_sequencer

Interface
REQ-001 SHALL have parameter GAP_TICKS, default 4, meaning the idle clk_in cycles inserted after every byte before the next start.
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 1024, meaning the maximum cycles to wait for spi_done after start.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, meaning the width of the per-frame byte counter.
REQ-004 SHALL have ports: clk_in input 1, the single clock; all logic on rising edge.
REQ-005 SHALL have ports: rstb input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: cmd_valid/cmd_last input 1 each, cmd_data input 8, cmd_ready output 1; command requester byte stream.
REQ-007 SHALL have ports: dbg_valid/dbg_last input 1 each, dbg_data input 8, dbg_ready output 1; debug requester byte stream.
REQ-008 SHALL have ports: dest_ready input 1, controller ready_for_data; no byte starts while low.
REQ-009 SHALL have ports: spi_start output 1, spi_tdat output 8, spi_done input 1; connect to spi_master start/tdat/done.
REQ-010 SHALL have ports: grant output 2 (01 cmd, 10 dbg, 00 none), busy output 1, byte_count output COUNT_WIDTH, err_timeout output 1, err_clr input 1.

Function
REQ-011 SHALL implement states IDLE, LOAD, XFER, GAP, HOLD.
REQ-012 IDLE: when dest_ready=1 and any valid=1, SHALL select a requester by frame-level round robin, set grant, and go to LOAD next cycle.
REQ-013 Round robin SHALL favour the requester not granted last; on tie after reset cmd wins.
REQ-014 LOAD: SHALL assert granted *_ready for exactly one cycle, capture data and last into spi_tdat and a last flag, and go to XFER.
REQ-015 XFER entry: SHALL assert spi_start for exactly one cycle, with spi_tdat held stable until the byte completes.
REQ-016 XFER: SHALL detect rising edge of spi_done; on edge, SHALL increment byte_count and go to GAP.
REQ-017 XFER: if no spi_done edge within TIMEOUT_TICKS cycles of spi_start, SHALL set sticky err_timeout, clear grant, and return to IDLE, abandoning the frame.
REQ-018 GAP: SHALL wait exactly GAP_TICKS cycles; then, if the last flag is set, go to IDLE, clear grant, and clear byte_count, else go to HOLD.
REQ-019 HOLD: SHALL keep grant (frame is atomic) until granted valid=1 and dest_ready=1, then go to LOAD; other requester is never served mid-frame.
REQ-020 dest_ready falling during XFER or GAP SHALL NOT abort the byte; it only blocks the next LOAD.
REQ-021 *_ready SHALL never assert for a non-granted requester, nor outside LOAD.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 byte_count SHALL saturate at all-ones, not wrap.
REQ-024 err_clr and a new timeout in the same cycle: set SHALL win.
REQ-025 GAP_TICKS=0 SHALL skip GAP, going directly from XFER to IDLE or HOLD on the done edge.

Reset
REQ-026 rstb low SHALL immediately force IDLE; spi_start, cmd_ready, dbg_ready, grant, busy, byte_count, err_timeout, and spi_tdat are 0; round-robin pointer is set so that cmd wins first.
REQ-027 Reset mid-frame SHALL discard the frame without retry; after release, arbitration restarts from IDLE.
REQ-028 The spi_done edge detector SHALL reset to 0 so that a done level high at release is not counted.

Structure
REQ-029 State enum and grant encodings (GRANT_NONE/CMD/DBG) SHALL live in the shared params package.
REQ-030 One sub-module, seq_tick_counter (loadable down-counter with zero flag), SHALL be instantiated for the GAP and timeout counts; everything else is in-module.

Verification
REQ-031 The bench SHALL cover: cmd 3-byte frame (A1,B2,C3 last), dest_ready=1, GAP_TICKS=4 -> three spi_start pulses, tdat A1,B2,C3, byte_count 3 then 0, grant back to 00.
REQ-032 The bench SHALL cover: cmd and dbg both valid from reset, 1-byte frames each, repeated -> grant order cmd,dbg,cmd,dbg.
REQ-033 The bench SHALL cover: dbg frame in progress, cmd_valid asserted mid-frame -> no cmd_ready until dbg_last byte done and GAP expires.
REQ-034 The bench SHALL cover: spi_done tied 0, TIMEOUT_TICKS=16 -> err_timeout=1 exactly 16 cycles after spi_start, IDLE; err_clr pulse -> 0.
REQ-035 The bench SHALL cover: dest_ready low between bytes 1 and 2 for 100 cycles -> state HOLD, grant kept, no spi_start; resume within 2 cycles of dest_ready rise.
REQ-036 The bench SHALL cover: rstb low during XFER of byte 2 -> all outputs 0 in the same cycle; the next cmd frame after release starts cleanly with byte_count 1 after its first byte.

Source files
------------

// File: rtl/spi_tx_sequencer_pkg.sv
// Shared types for the SPI transmit sequencer: FSM states, grant encodings
// and the frame-level round-robin pick.
package spi_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        XFER,
        GAP,
        HOLD
    } seq_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_CMD  = 2'b01;
    localparam logic [1:0] GRANT_DBG  = 2'b10;

    // On a tie the requester that did not own the previous frame wins.
    function automatic logic [1:0] rr_pick(input logic cmd_v, input logic dbg_v,
                                           input logic last_was_cmd);
        if (cmd_v && dbg_v) return last_was_cmd ? GRANT_DBG : GRANT_CMD;
        if (cmd_v)          return GRANT_CMD;
        if (dbg_v)          return GRANT_DBG;
        return GRANT_NONE;
    endfunction

endpackage

// File: rtl/spi_tx_sequencer_if.sv
// Byte-stream requesters, destination readiness and spi_master hookup.
interface spi_tx_sequencer_if;
    logic       cmd_valid;
    logic       cmd_last;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       dbg_valid;
    logic       dbg_last;
    logic [7:0] dbg_data;
    logic       dbg_ready;
    logic       dest_ready;
    logic       spi_start;
    logic [7:0] spi_tdat;
    logic       spi_done;

    // master: the sequencer itself; slave: requesters plus spi_master side
    modport master (
        input  cmd_valid, cmd_last, cmd_data, dbg_valid, dbg_last, dbg_data,
        input  dest_ready, spi_done,
        output cmd_ready, dbg_ready, spi_start, spi_tdat
    );

    modport slave (
        output cmd_valid, cmd_last, cmd_data, dbg_valid, dbg_last, dbg_data,
        output dest_ready, spi_done,
        input  cmd_ready, dbg_ready, spi_start, spi_tdat
    );
endinterface

// File: rtl/spi_tx_sequencer_tick_counter.sv
// Loadable down-counter with zero flag; stops at zero rather than wrapping.
module seq_tick_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 count <= '0;
        else if (load)              count <= load_val;
        else if (en && count != '0) count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/spi_tx_sequencer.sv
// Arbitrates two byte-stream requesters onto one spi_master, one atomic frame
// at a time, with inter-byte gap, done timeout and per-frame byte count.
module spi_tx_sequencer
    import spi_tx_sequencer_pkg::*;
#(
    parameter int GAP_TICKS     = 4,
    parameter int TIMEOUT_TICKS = 1024,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk_in,
    input  logic                   rstb,
    spi_tx_sequencer_if.master     bus,
    output logic [1:0]             grant,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] byte_count,
    output logic                   err_timeout,
    input  logic                   err_clr
);

    localparam int TICK_MAX = (TIMEOUT_TICKS > GAP_TICKS) ? TIMEOUT_TICKS : GAP_TICKS;
    localparam int TW       = $clog2(TICK_MAX + 1);
    // Counter holds N-1 on the first cycle of an N-cycle window.
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    seq_state_e  state, state_nxt;
    logic        last_was_cmd;
    logic        last_q;
    logic        start_q;
    logic [7:0]  tdat_q;
    logic        done_q;
    logic        done_rise;
    logic [1:0]  pick;
    logic        granted_valid;

    logic        do_grant, do_load, byte_done, frame_end, timeout;
    logic        cnt_load, cnt_en, cnt_zero;
    logic [TW-1:0] cnt_val, cnt_count;

    seq_tick_counter #(.WIDTH(TW)) u_tick (
        .clk      (clk_in),
        .rst_n    (rstb),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    assign done_rise     = bus.spi_done & ~done_q;
    assign pick          = rr_pick(bus.cmd_valid, bus.dbg_valid, last_was_cmd);
    assign granted_valid = (grant == GRANT_CMD) ? bus.cmd_valid :
                           (grant == GRANT_DBG) ? bus.dbg_valid : 1'b0;
    assign cnt_en        = (state == XFER) || (state == GAP);

    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_load   = 1'b0;
        byte_done = 1'b0;
        frame_end = 1'b0;
        timeout   = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = TO_LOAD;
        case (state)
            IDLE: begin
                if (bus.dest_ready && pick != GRANT_NONE) begin
                    do_grant  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                do_load   = 1'b1;
                cnt_load  = 1'b1;
                cnt_val   = TO_LOAD;
                state_nxt = XFER;
            end
            XFER: begin
                if (done_rise) begin
                    byte_done = 1'b1;
                    if (GAP_TICKS == 0) begin
                        frame_end = last_q;
                        state_nxt = last_q ? IDLE : HOLD;
                    end else begin
                        cnt_load  = 1'b1;
                        cnt_val   = GAP_LOAD;
                        state_nxt = GAP;
                    end
                end else if (cnt_zero) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    frame_end = last_q;
                    state_nxt = last_q ? IDLE : HOLD;
                end
            end
            HOLD: begin
                // Frame is atomic: only the granted requester can continue it.
                if (granted_valid && bus.dest_ready) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            grant        <= GRANT_NONE;
            last_was_cmd <= 1'b0;
            tdat_q       <= '0;
            last_q       <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            byte_count   <= '0;
            err_timeout  <= 1'b0;
        end else begin
            if (do_grant) begin
                grant        <= pick;
                last_was_cmd <= (pick == GRANT_CMD);
            end else if (frame_end || timeout) begin
                grant <= GRANT_NONE;
            end

            if (do_load) begin
                tdat_q <= (grant == GRANT_DBG) ? bus.dbg_data : bus.cmd_data;
                last_q <= (grant == GRANT_DBG) ? bus.dbg_last : bus.cmd_last;
            end

            start_q <= do_load;
            done_q  <= bus.spi_done;

            if (frame_end || timeout)
                byte_count <= '0;
            else if (byte_done && byte_count != '1)
                byte_count <= byte_count + 1'b1;

            if (timeout)      err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
        end
    end

    assign bus.cmd_ready = (state == LOAD) && (grant == GRANT_CMD);
    assign bus.dbg_ready = (state == LOAD) && (grant == GRANT_DBG);
    assign bus.spi_start = start_q;
    assign bus.spi_tdat  = tdat_q;
    assign busy          = (state != IDLE);

endmodule
